norm_shift: RTL and testbench

NORM_SHIFT -- requirements
Module: norm_shift

---
 rtl/norm_shift_pkg.sv | 14 +
 rtl/norm_shift_clz.sv | 21 ++
 rtl/norm_shift.sv | 79 +++++++
 tb/tb_norm_shift.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/norm_shift_pkg.sv
// norm_shift_pkg: shared default widths and log2 helper for the normalizer
package norm_shift_pkg;

    localparam int NS_BITS_IN = 16;

    function automatic int ns_log2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int NS_BITS_OUT = ns_log2(NS_BITS_IN);

endpackage

// File: rtl/norm_shift_clz.sv
// norm_shift_clz: combinational count-leading-zeros; all-zero word gives all-ones count and vout=0
module norm_shift_clz
    import norm_shift_pkg::*;
#(
    parameter int W  = NS_BITS_IN,
    parameter int CW = NS_BITS_OUT
) (
    input  logic [W-1:0]  b,
    output logic [CW-1:0] pout,
    output logic          vout
);

    // scan upward so the highest set bit writes the final count
    always_comb begin
        pout = '1;
        vout = |b;
        for (int i = 0; i < W; i++)
            if (b[i]) pout = CW'(W - 1 - i);
    end

endmodule

// File: rtl/norm_shift.sv
// norm_shift: two-stage valid/ready normalizer (clz in S1, barrel shift in S2)
module norm_shift
    import norm_shift_pkg::*;
#(
    parameter int BITS_IN  = NS_BITS_IN,
    parameter int BITS_OUT = ns_log2(BITS_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS_IN-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS_IN-1:0]  out_mant,
    output logic [BITS_OUT-1:0] out_shift,
    output logic                out_zero
);

    logic                s1_valid;
    logic [BITS_IN-1:0]  s1_data;
    logic [BITS_OUT-1:0] s1_cnt;
    logic                s1_nz;
    logic [BITS_OUT-1:0] clz_cnt;
    logic                clz_nz;
    logic                s2_adv;
    logic [BITS_IN-1:0]  lvl [BITS_OUT+1];

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    norm_shift_clz #(.W(BITS_IN), .CW(BITS_OUT)) u_clz (
        .b    (in_data),
        .pout (clz_cnt),
        .vout (clz_nz)
    );

    // S1 occupancy: refill whenever the stage can hand its word on
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    // S1 payload: only loaded on an input transfer, never reset
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_data <= in_data;
            s1_cnt  <= clz_cnt;
            s1_nz   <= clz_nz;
        end
    end

    // zero words bypass the shift so the mantissa stays all zeros
    assign lvl[0] = s1_nz ? s1_data : '0;

    for (genvar k = 0; k < BITS_OUT; k++) begin : g_shift
        assign lvl[k+1] = s1_cnt[k] ? lvl[k] << (2 ** k) : lvl[k];
    end

    // S2 output register: holds steady while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant  <= lvl[BITS_OUT];
                out_shift <= s1_cnt;
                out_zero  <= !s1_nz;
            end
        end
    end

endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: directed and scoreboarded checks of the normalizer
module tb_norm_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [3:0]  out_shift;
    logic        out_zero;

    int n_chk = 0;
    int n_fail = 0;
    int pops = 0;
    bit done = 0;
    logic [20:0] q [$];

    norm_shift dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] exp_of(input logic [15:0] d);
        int n = 0;
        logic [15:0] m = d;
        if (d == 16'h0) return {1'b1, 4'hF, 16'h0};
        while (!m[15]) begin
            m = m << 1;
            n++;
        end
        return {1'b0, 4'(n), m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk(tag, q.size(), 0);
    endtask

    // scoreboard: pop the oldest expectation on each output transfer, push on each input transfer
    always @(negedge clk) begin
        logic [20:0] e;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_mant", out_mant, e[15:0]);
                    chk("sb_shift", out_shift, e[19:16]);
                    chk("sb_zero", out_zero, e[20]);
                end
            end
            if (in_valid && in_ready) q.push_back(exp_of(in_data));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 16'h0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mant", out_mant, 0);
        chk("rst_shift", out_shift, 0);
        chk("rst_zero", out_zero, 0);
        rst = 1'b0;
        step();

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h0001;
        step();
        in_valid = 1'b0;
        chk("lat_valid_early", out_valid, 0);
        step();
        chk("lat_valid", out_valid, 1);
        chk("one_mant", out_mant, 16'h8000);
        chk("one_shift", out_shift, 15);
        chk("one_zero", out_zero, 0);
        step();

        in_valid = 1'b1;
        in_data = 16'h0000;
        step();
        in_valid = 1'b0;
        step();
        chk("zero_valid", out_valid, 1);
        chk("zero_mant", out_mant, 16'h0000);
        chk("zero_shift", out_shift, 4'hF);
        chk("zero_zero", out_zero, 1);
        step();

        in_valid = 1'b1;
        in_data = 16'h8000;
        step();
        in_data = 16'h00F0;
        step();
        chk("b2b0_mant", out_mant, 16'h8000);
        chk("b2b0_shift", out_shift, 0);
        in_data = 16'h0300;
        step();
        in_valid = 1'b0;
        chk("b2b1_valid", out_valid, 1);
        chk("b2b1_mant", out_mant, 16'hF000);
        chk("b2b1_shift", out_shift, 8);
        step();
        chk("b2b2_valid", out_valid, 1);
        chk("b2b2_mant", out_mant, 16'hC000);
        chk("b2b2_shift", out_shift, 6);
        step();
        chk("b2b_empty", out_valid, 0);

        out_ready = 1'b0;
        p0 = pops;
        send(16'h0010);
        send(16'h0400);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_mant", out_mant, 16'h8000);
            chk("stall_shift", out_shift, 11);
            step();
        end
        out_ready = 1'b1;
        send(16'h0000);
        send(16'h7FFF);
        drain("stall_drain");
        chk("stall_count", pops - p0, 4);

        out_ready = 1'b0;
        send(16'h1234);
        send(16'h0FFF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_mant", out_mant, 0);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_quiet", out_valid, 0);
            step();
        end
        p0 = pops;
        send(16'h0002);
        drain("post_rst_drain");
        chk("post_rst_count", pops - p0, 1);

        p0 = pops;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send(16'($urandom) >> $urandom_range(0, 16));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain("rand_drain");
        chk("rand_count", pops - p0, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
